core_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32 core: owns `pc`, the machine `state` broadcast to fetch/decoder/execute, and the handshakes with instruction and data memory. Replaces the fixed four-step loop with one that waits on memory acknowledges, inserts a MEM step only for loads/stores, gates register writeback, counts retired instructions and halts cleanly. Sits at the top of the core, between the memory ports and the datapath units.

---
 rtl/core_ctrl_pkg.sv | 17 +
 rtl/core_ctrl_next_pc.sv | 21 ++
 rtl/core_ctrl.sv | 79 +++++++
 tb/tb_core_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared step encoding for the RV32 sequencer; fetch, decoder and execute
// decode the broadcast state against these values.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WRITE  = 3'd5,
    HALTED = 3'd6
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/core_ctrl_next_pc.sv
// Next-pc select: sequential pc+4 or jump target, with word-alignment check.
module next_pc
  import core_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        is_jump_enabled,
  input  logic [31:0] jump_dest,
  output logic [31:0] npc,
  output logic        misalign
);

  assign misalign = is_jump_enabled && (jump_dest[1:0] != 2'b00);

  // A misaligned target leaves pc pointing at the faulting instruction.
  always_comb begin
    npc = pc + PC_STEP;
    if (misalign)             npc = pc;
    else if (is_jump_enabled) npc = jump_dest;
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer: owns pc and the machine step, handshakes with
// instruction/data memory, gates writeback, counts retirements and halts.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        is_mem_op,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        is_jump_enabled,
  input  logic [31:0] jump_dest,
  input  logic        halt,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic [31:0] pc_instr,
  output logic        reg_write_gate,
  output logic [31:0] retired,
  output logic        misaligned
);

  state_t      state_q, state_d;
  logic        halt_pending;
  logic [31:0] npc;
  logic        jump_misalign;

  next_pc u_next_pc (
    .pc              (pc),
    .is_jump_enabled (is_jump_enabled),
    .jump_dest       (jump_dest),
    .npc             (npc),
    .misalign        (jump_misalign)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (fetch_ack) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = is_mem_op ? MEM : WRITE;
      MEM:     if (mem_ack) state_d = WRITE;
      // A halt arriving during WRITE itself still stops after this retirement.
      WRITE:   state_d = (jump_misalign || halt_pending || halt) ? HALTED : FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  assign state          = state_q;
  assign fetch_req      = (state_q == FETCH);
  assign mem_req        = (state_q == MEM);
  assign reg_write_gate = (state_q == WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc           <= RESET_PC;
      pc_instr     <= 32'h0;
      retired      <= 32'h0;
      misaligned   <= 1'b0;
      halt_pending <= 1'b0;
    end else begin
      state_q <= state_d;
      if (halt) halt_pending <= 1'b1;
      if (state_q == DECODE) pc_instr <= pc;
      if (state_q == WRITE) begin
        retired <= retired + 32'd1;
        pc      <= npc;
        if (jump_misalign) misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: sequencing, memory waits, jumps, halt, wrap, reset.
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_ack, is_mem_op, mem_req, mem_ack;
  logic        is_jump_enabled, halt, reg_write_gate, misaligned;
  logic [31:0] jump_dest, pc, pc_instr, retired;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                          S_MEM = 4, S_WRITE = 5, S_HALTED = 6;

  always #5 clk = ~clk;

  core_ctrl #(.RESET_PC(RPC)) dut (
    .clk (clk), .rst (rst),
    .fetch_req (fetch_req), .fetch_ack (fetch_ack),
    .is_mem_op (is_mem_op), .mem_req (mem_req), .mem_ack (mem_ack),
    .is_jump_enabled (is_jump_enabled), .jump_dest (jump_dest),
    .halt (halt), .state (state), .pc (pc), .pc_instr (pc_instr),
    .reg_write_gate (reg_write_gate), .retired (retired), .misaligned (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rst released at a negedge with the DUT in IDLE.
  task automatic do_reset();
    rst = 1'b1;
    fetch_ack = 1'b1; mem_ack = 1'b1; is_mem_op = 1'b0;
    is_jump_enabled = 1'b0; jump_dest = 32'h0; halt = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_state", {29'h0, state}, S_IDLE);
    chk("rst_pc", pc, RPC);
    chk("rst_pc_instr", pc_instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_reqs", {29'h0, fetch_req, mem_req, reg_write_gate}, 32'h0);
    chk("rst_misaligned", {31'h0, misaligned}, 32'h0);

    // Sequential run, zero-wait acks
    step(1);
    chk("seq_fetch", {29'h0, state}, S_FETCH);
    chk("seq_fetch_req", {31'h0, fetch_req}, 32'h1);
    step(1);
    chk("seq_decode", {29'h0, state}, S_DECODE);
    chk("seq_fetch_req_drop", {31'h0, fetch_req}, 32'h0);
    step(2);
    chk("seq_write", {29'h0, state}, S_WRITE);
    chk("seq_wgate", {31'h0, reg_write_gate}, 32'h1);
    chk("seq_pc_instr", pc_instr, RPC);
    step(1);
    chk("seq_pc1", pc, 32'h104);
    step(4);
    chk("seq_pc2", pc, 32'h108);
    step(4);
    chk("seq_pc3", pc, 32'h10C);
    chk("seq_retired3", retired, 32'd3);

    // Load/store with mem_ack delayed 3 cycles
    do_reset();
    is_mem_op = 1'b1; mem_ack = 1'b0;
    step(4);
    chk("mem_enter", {29'h0, state}, S_MEM);
    chk("mem_req0", {31'h0, mem_req}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("mem_hold%0d", i), {29'h0, state, mem_req}, {S_MEM[27:0], 1'b1});
    end
    mem_ack = 1'b1;
    step(1);
    chk("mem_write", {29'h0, state}, S_WRITE);
    chk("mem_req_drop", {31'h0, mem_req}, 32'h0);
    mem_ack = 1'b0; is_mem_op = 1'b0;
    step(1);
    chk("mem_next_fetch", {29'h0, state}, S_FETCH);
    chk("mem_pc", pc, 32'h104);
    chk("mem_retired", retired, 32'd1);

    // Aligned jump then misaligned jump
    do_reset();
    step(4);
    is_jump_enabled = 1'b1; jump_dest = 32'h2000;
    step(1);
    is_jump_enabled = 1'b0;
    chk("jmp_pc", pc, 32'h2000);
    chk("jmp_fetch_req", {31'h0, fetch_req}, 32'h1);
    step(3);
    chk("jmp2_write", {29'h0, state}, S_WRITE);
    is_jump_enabled = 1'b1; jump_dest = 32'h2002;
    step(1);
    is_jump_enabled = 1'b0;
    chk("mis_flag", {31'h0, misaligned}, 32'h1);
    chk("mis_state", {29'h0, state}, S_HALTED);
    chk("mis_pc", pc, 32'h2000);
    step(3);
    chk("mis_stays", {29'h0, state, fetch_req}, {S_HALTED[27:0], 1'b0});

    // Halt pulse during DECODE
    do_reset();
    step(2);
    chk("halt_in_decode", {29'h0, state}, S_DECODE);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    step(1);
    chk("halt_write", {29'h0, state}, S_WRITE);
    step(1);
    chk("halt_state", {29'h0, state}, S_HALTED);
    chk("halt_retired", retired, 32'd1);
    chk("halt_pc", pc, 32'h104);
    step(4);
    chk("halt_no_fetch", {29'h0, state, fetch_req}, {S_HALTED[27:0], 1'b0});
    chk("halt_no_misalign", {31'h0, misaligned}, 32'h0);

    // pc wrap past the top of the address space
    do_reset();
    step(4);
    is_jump_enabled = 1'b1; jump_dest = 32'hFFFF_FFFC;
    step(1);
    is_jump_enabled = 1'b0;
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    step(4);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_retired", retired, 32'd2);

    // Reset asserted in the middle of a MEM wait
    do_reset();
    step(4);
    is_mem_op = 1'b1; mem_ack = 1'b0;
    step(4);
    chk("rmem_in_mem", {29'h0, state, mem_req}, {S_MEM[27:0], 1'b1});
    chk("rmem_pc_before", pc, 32'h104);
    rst = 1'b1;
    #1;
    chk("rmem_req_drop", {31'h0, mem_req}, 32'h0);
    chk("rmem_state", {29'h0, state}, S_IDLE);
    chk("rmem_pc", pc, RPC);
    chk("rmem_retired", retired, 32'h0);
    chk("rmem_pc_instr", pc_instr, 32'h0);
    is_mem_op = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("rmem_refetch", {29'h0, state, fetch_req}, {S_FETCH[27:0], 1'b1});
    chk("rmem_refetch_pc", pc, RPC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
